// File: rtl/sequence_transmitter.sv
// Serial generator for PATTERN (MSB first), one bit per BIT_DIV clocks, framed by a GAP_BITS idle gap.
// Optional build macro SEQ_TX_HEX_EN: HEX0 shows bit index, HEX1 shows frame count mod 10.
module sequence_transmitter #(
    parameter int                 PAT_LEN  = 7,
    parameter logic [PAT_LEN-1:0] PATTERN  = 7'b1100111,
    parameter int                 BIT_DIV  = 50000000,
    parameter int                 GAP_BITS = 3
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic       tx_bit,
    output logic       tx_strobe,
    output logic       tx_busy,
    output logic       frame_done,
    output logic [2:0] currentState,
    output logic [9:0] LEDR,
    output logic [7:0] LEDG,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3
);
    localparam int GAP_CYC = GAP_BITS * BIT_DIV;
    localparam int CNT_W   = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        GAP  = 3'd2
    } state_t;

    state_t             state, state_d;
    logic               rst_n;
    logic [2:0]         key_sync;
    logic               start_evt;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         bit_idx;
    logic [PAT_LEN-1:0] shreg;
    logic [PAT_LEN-1:0] shifted;
    logic               load, shift, finish;
    logic               unused;

    assign rst_n   = KEY[0];
    assign unused  = &{1'b0, KEY[2:1], SW[9:1]};
    assign shifted = shreg << 1;

    // key_sync[1] is the synchronized button; key_sync[2] is its previous value for fall detection.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            key_sync <= 3'b111;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, giving a true shift chain.
            key_sync <= {key_sync[1:0], KEY[3]};
        end
    end

    assign start_evt = key_sync[2] & ~key_sync[1];

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_d = state;
        load    = 1'b0;
        shift   = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (start_evt) begin
                    state_d = SEND;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (cnt == CNT_W'(BIT_DIV - 1)) begin
                    if (bit_idx != 4'd0) begin
                        shift = 1'b1;
                    end else begin
                        finish  = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    if (SW[0]) begin
                        load    = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx_bit     <= 1'b0;
            tx_strobe  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_strobe  <= 1'b0;
            frame_done <= 1'b0;
            if (load) begin
                cnt       <= '0;
                bit_idx   <= 4'(PAT_LEN - 1);
                shreg     <= PATTERN;
                tx_bit    <= PATTERN[PAT_LEN-1];
                tx_strobe <= 1'b1;
            end else if (shift) begin
                cnt       <= '0;
                bit_idx   <= bit_idx - 4'd1;
                shreg     <= shifted;
                tx_bit    <= shifted[PAT_LEN-1];
                tx_strobe <= 1'b1;
            end else if (finish) begin
                cnt        <= '0;
                shreg      <= '0;
                tx_bit     <= 1'b0;
                frame_done <= 1'b1;
            end else if (state_d == state && state != IDLE) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

`ifdef SEQ_TX_HEX_EN
    logic [3:0] frame_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n)      frame_cnt <= '0;
        else if (finish) frame_cnt <= (frame_cnt == 4'd9) ? 4'd0 : frame_cnt + 4'd1;
    end

    // Active-low segments {DP, g..a}; anything above 9 blanks the digit.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction
`endif

    always_comb begin
        tx_busy      = (state == SEND) || (state == GAP);
        currentState = state;
        LEDR         = 10'(shreg);
        LEDG         = {6'b0, tx_busy, tx_bit};
        HEX3         = 8'hFF;
        HEX2         = 8'hFF;
`ifdef SEQ_TX_HEX_EN
        HEX1         = seg7(frame_cnt);
        HEX0         = tx_busy ? seg7(bit_idx) : 8'hFF;
`else
        HEX1         = 8'hFF;
        HEX0         = 8'hFF;
`endif
    end

endmodule
